// File: rtl/sram_lsu_pkg.sv
// Shared definitions for the SRAM load/store unit: funct3 codes, FSM states,
// byte write-enable masks and request decode helpers.
package sram_lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] WEN_NONE = 4'b0000;
  localparam logic [3:0] WEN_B    = 4'b0001;
  localparam logic [3:0] WEN_H    = 4'b0011;
  localparam logic [3:0] WEN_W    = 4'b1111;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Unsigned loads exist only as loads; stores accept B/H/W.
  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    case (f3)
      F3_B, F3_H, F3_W: f3_legal = 1'b1;
      F3_BU, F3_HU:     f3_legal = !we;
      default:          f3_legal = 1'b0;
    endcase
  endfunction

  // Access size minus one, used for the no-wrap check.
  function automatic logic [1:0] size_m1(input logic [2:0] f3);
    case (f3)
      F3_H, F3_HU: size_m1 = 2'd1;
      F3_W:        size_m1 = 2'd3;
      default:     size_m1 = 2'd0;
    endcase
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lo);
    case (f3)
      F3_H, F3_HU: misaligned = lo[0];
      F3_W:        misaligned = |lo;
      default:     misaligned = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] wen_mask(input logic [2:0] f3);
    case (f3)
      F3_B:    wen_mask = WEN_B;
      F3_H:    wen_mask = WEN_H;
      F3_W:    wen_mask = WEN_W;
      default: wen_mask = WEN_NONE;
    endcase
  endfunction

endpackage

// File: rtl/sram_lsu_if.sv
// Core-side request/response channel of the SRAM load/store unit.
// Handshake: a transfer happens on a rising edge where valid && ready are both high;
// the sender holds valid and payload stable until that edge, ready never depends on valid.
interface sram_lsu_if #(
  parameter int ADDR_W = 16
) ();
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [31:0]       resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/sram_lsu_load_ext.sv
// Load data extension: picks the low byte/half/word of the raw SRAM word
// and sign- or zero-extends it according to funct3.
module sram_lsu_load_ext
  import sram_lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] raw,
  output logic [31:0] data
);

  always_comb begin
    data = raw;
    case (funct3)
      F3_B:    data = {{24{raw[7]}}, raw[7:0]};
      F3_BU:   data = {24'h0, raw[7:0]};
      F3_H:    data = {{16{raw[15]}}, raw[15:0]};
      F3_HU:   data = {16'h0, raw[15:0]};
      default: data = raw;
    endcase
  end

endmodule

// File: rtl/sram_lsu.sv
// Load/store initiator for a byte-addressed 32-bit SRAM: one request per
// handshake, IDLE -> ACCESS -> RESP, with illegal requests answered directly from IDLE.
module sram_lsu
  import sram_lsu_pkg::*;
#(
  parameter int ADDR_W         = 16,
  parameter bit ALLOW_MISALIGN = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  sram_lsu_if.slave         bus,
  output logic [ADDR_W-1:0] sram_address,
  output logic [3:0]        sram_w_en,
  output logic [31:0]       sram_wdata,
  input  logic [31:0]       sram_rdata,
  output state_t            dbg_state
);

  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  state_t      state, state_nxt;
  logic        ready_q;
  logic        resp_valid_q;
  logic        resp_err_q;
  logic [31:0] resp_rdata_q;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [31:0] ext_data;
  logic        accept;
  logic        resp_done;
  logic        wraps;
  logic        req_ok;

  assign accept    = bus.req_valid && ready_q;
  assign resp_done = resp_valid_q && bus.resp_ready;

  // Last byte of the access must not run past the top of the address space.
  assign wraps  = bus.req_addr > (ADDR_MAX - ADDR_W'(size_m1(bus.req_funct3)));
  assign req_ok = f3_legal(bus.req_we, bus.req_funct3) && !wraps &&
                  (ALLOW_MISALIGN || !misaligned(bus.req_funct3, bus.req_addr[1:0]));

  sram_lsu_load_ext u_load_ext (
    .funct3 (f3_q),
    .raw    (sram_rdata),
    .data   (ext_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = req_ok ? ACCESS : RESP;
      ACCESS:  state_nxt = RESP;
      RESP:    if (resp_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q      <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'h0;
      we_q         <= 1'b0;
      f3_q         <= F3_W;
      sram_address <= '0;
      sram_w_en    <= WEN_NONE;
      sram_wdata   <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            ready_q <= 1'b0;
            if (req_ok) begin
              we_q         <= bus.req_we;
              f3_q         <= bus.req_funct3;
              sram_address <= bus.req_addr;
              sram_wdata   <= bus.req_wdata;
              sram_w_en    <= bus.req_we ? wen_mask(bus.req_funct3) : WEN_NONE;
            end else begin
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_rdata_q <= 32'h0;
            end
          end
        end
        ACCESS: begin
          // Write commits and read data is captured on this same edge.
          sram_w_en    <= WEN_NONE;
          resp_valid_q <= 1'b1;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= we_q ? 32'h0 : ext_data;
        end
        RESP: begin
          if (resp_done) begin
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'h0;
            ready_q      <= 1'b1;
          end
        end
        default: begin
          sram_w_en <= WEN_NONE;
          ready_q   <= 1'b1;
        end
      endcase
    end
  end

  assign bus.req_ready  = ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign dbg_state      = state;

endmodule

// File: tb/tb_sram_lsu.sv
// Directed bench for sram_lsu with a byte-lane SRAM model and
// hand-computed expected load data.
module tb_sram_lsu;
  import sram_lsu_pkg::*;

  localparam int ADDR_W = 16;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sram_lsu_if #(.ADDR_W(ADDR_W)) bus ();

  logic [ADDR_W-1:0] sram_address;
  logic [3:0]        sram_w_en;
  logic [31:0]       sram_wdata;
  logic [31:0]       sram_rdata;
  state_t            dbg_state;

  sram_lsu #(.ADDR_W(ADDR_W), .ALLOW_MISALIGN(1'b0)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .sram_address (sram_address),
    .sram_w_en    (sram_w_en),
    .sram_wdata   (sram_wdata),
    .sram_rdata   (sram_rdata),
    .dbg_state    (dbg_state)
  );

  // SRAM model: byte lane i lives at address+i, combinational read
  logic [7:0] mem [0:65535];
  logic       mem_clear = 1'b1;
  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 65536; i++) mem[i] <= 8'h00;
    end else begin
      for (int i = 0; i < 4; i++)
        if (sram_w_en[i]) mem[sram_address + 16'(i)] <= sram_wdata[8*i +: 8];
    end
  end
  assign sram_rdata = {mem[sram_address + 16'd3], mem[sram_address + 16'd2],
                       mem[sram_address + 16'd1], mem[sram_address]};

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int pass_cnt = 0;
  int check_cnt = 0;
  logic [31:0] exp_q[$];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver: one full transaction, returns what was observed
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [15:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rdata, output logic err,
                        output int lat, output logic [3:0] wen, output int wen_cnt,
                        output logic [15:0] wen_addr, output int acc_cyc);
    int guard = 0;
    wen = 4'h0; wen_cnt = 0; wen_addr = 16'h0; rdata = 32'h0; err = 1'b0; acc_cyc = 0;
    while (!bus.req_ready && guard < 20) begin
      @(posedge clk); #1; guard++;
    end
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_funct3 = f3;
    bus.req_addr = addr; bus.req_wdata = wdata;
    @(posedge clk); #1;
    acc_cyc = cyc;
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.resp_valid && lat < 10) begin
      if (sram_w_en != 4'h0) begin wen = sram_w_en; wen_cnt++; wen_addr = sram_address; end
      @(posedge clk); #1; lat++;
    end
    if (sram_w_en != 4'h0) wen_cnt++;
    if (guard >= 20) lat = -1;
    rdata = bus.resp_rdata;
    err = bus.resp_err;
  endtask

  task automatic test_reset();
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = F3_W;
    bus.req_addr = '0; bus.req_wdata = '0; bus.resp_ready = 1'b1;
    rst_n = 1'b0; mem_clear = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_cnt++; if (bus.req_ready !== 1'b1) $display("FAIL reset_req_ready: got %b want 1", bus.req_ready); else pass_cnt++;
    check_cnt++; if (bus.resp_valid !== 1'b0) $display("FAIL reset_resp_valid: got %b want 0", bus.resp_valid); else pass_cnt++;
    check_cnt++; if (bus.resp_err !== 1'b0) $display("FAIL reset_resp_err: got %b want 0", bus.resp_err); else pass_cnt++;
    check_cnt++; if (bus.resp_rdata !== 32'h0) $display("FAIL reset_resp_rdata: got %h want 0", bus.resp_rdata); else pass_cnt++;
    check_cnt++; if (sram_w_en !== 4'h0) $display("FAIL reset_w_en: got %b want 0000", sram_w_en); else pass_cnt++;
    check_cnt++; if (sram_address !== 16'h0) $display("FAIL reset_address: got %h want 0", sram_address); else pass_cnt++;
    check_cnt++; if (sram_wdata !== 32'h0) $display("FAIL reset_wdata: got %h want 0", sram_wdata); else pass_cnt++;
    check_cnt++; if (dbg_state !== IDLE) $display("FAIL reset_state: got %0d want %0d", dbg_state, IDLE); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1; mem_clear = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_store_load();
    logic [31:0] r; logic e; int lat, wc, ac; logic [3:0] w; logic [15:0] wa;
    do_req(1'b1, F3_W, 16'h0010, 32'hDEADBEEF, r, e, lat, w, wc, wa, ac);
    check_cnt++; if (w !== 4'b1111) $display("FAIL sw_w_en: got %b want 1111", w); else pass_cnt++;
    check_cnt++; if (wc !== 1) $display("FAIL sw_w_en_cycles: got %0d want 1", wc); else pass_cnt++;
    check_cnt++; if (wa !== 16'h0010) $display("FAIL sw_address: got %h want 0010", wa); else pass_cnt++;
    check_cnt++; if (lat !== 2) $display("FAIL sw_latency: got %0d want 2", lat); else pass_cnt++;
    check_cnt++; if (r !== 32'h0 || e !== 1'b0) $display("FAIL sw_resp: got %h/%b want 0/0", r, e); else pass_cnt++;
    do_req(1'b0, F3_W, 16'h0010, 32'h0, r, e, lat, w, wc, wa, ac);
    check_cnt++; if (r !== 32'hDEADBEEF) $display("FAIL lw_rdata: got %h want deadbeef", r); else pass_cnt++;
    check_cnt++; if (e !== 1'b0) $display("FAIL lw_err: got %b want 0", e); else pass_cnt++;
    check_cnt++; if (lat !== 2) $display("FAIL lw_latency: got %0d want 2", lat); else pass_cnt++;
    check_cnt++; if (wc !== 0) $display("FAIL lw_w_en_cycles: got %0d want 0", wc); else pass_cnt++;
  endtask

  task automatic test_extend();
    logic [2:0]  f3s [4] = '{F3_B, F3_BU, F3_H, F3_HU};
    logic [15:0] adrs [4] = '{16'h0013, 16'h0013, 16'h0012, 16'h0012};
    logic [31:0] r, exp; logic e; int lat, wc, ac; logic [3:0] w; logic [15:0] wa;
    exp_q.push_back(32'hFFFFFFDE);
    exp_q.push_back(32'h000000DE);
    exp_q.push_back(32'hFFFFDEAD);
    exp_q.push_back(32'h0000DEAD);
    for (int i = 0; i < 4; i++) begin
      do_req(1'b0, f3s[i], adrs[i], 32'h0, r, e, lat, w, wc, wa, ac);
      exp = exp_q.pop_front();
      check_cnt++; if (r !== exp || e !== 1'b0) $display("FAIL ext_f3_%0d: got %h/%b want %h/0", f3s[i], r, e, exp); else pass_cnt++;
    end
  endtask

  task automatic test_partial_store();
    logic [31:0] r; logic e; int lat, wc, ac; logic [3:0] w; logic [15:0] wa;
    do_req(1'b1, F3_B, 16'h0011, 32'h00000055, r, e, lat, w, wc, wa, ac);
    check_cnt++; if (w !== 4'b0001 || wc !== 1) $display("FAIL sb_w_en: got %b x%0d want 0001 x1", w, wc); else pass_cnt++;
    do_req(1'b0, F3_W, 16'h0010, 32'h0, r, e, lat, w, wc, wa, ac);
    check_cnt++; if (r !== 32'hDEAD55EF) $display("FAIL sb_readback: got %h want dead55ef", r); else pass_cnt++;
    do_req(1'b1, F3_H, 16'h0012, 32'h00001234, r, e, lat, w, wc, wa, ac);
    check_cnt++; if (w !== 4'b0011 || wc !== 1) $display("FAIL sh_w_en: got %b x%0d want 0011 x1", w, wc); else pass_cnt++;
    do_req(1'b0, F3_W, 16'h0010, 32'h0, r, e, lat, w, wc, wa, ac);
    check_cnt++; if (r !== 32'h123455EF) $display("FAIL sh_readback: got %h want 123455ef", r); else pass_cnt++;
  endtask

  task automatic test_errors();
    logic [31:0] r; logic e; int lat, wc, ac; logic [3:0] w; logic [15:0] wa;
    do_req(1'b0, F3_W, 16'h0011, 32'h0, r, e, lat, w, wc, wa, ac);
    check_cnt++; if (e !== 1'b1 || r !== 32'h0) $display("FAIL lw_misalign: got err %b rdata %h want 1/0", e, r); else pass_cnt++;
    check_cnt++; if (lat !== 1 || wc !== 0) $display("FAIL lw_misalign_path: got lat %0d wen %0d want 1/0", lat, wc); else pass_cnt++;
    do_req(1'b1, F3_W, 16'hFFFE, 32'hA5A5A5A5, r, e, lat, w, wc, wa, ac);
    check_cnt++; if (e !== 1'b1 || r !== 32'h0 || wc !== 0) $display("FAIL sw_wrap: got err %b rdata %h wen %0d want 1/0/0", e, r, wc); else pass_cnt++;
    check_cnt++; if (mem[16'hFFFE] !== 8'h00 || mem[16'hFFFF] !== 8'h00 || mem[0] !== 8'h00)
      $display("FAIL sw_wrap_mem: got %h %h %h want 00 00 00", mem[16'hFFFE], mem[16'hFFFF], mem[0]); else pass_cnt++;
    do_req(1'b0, 3'b011, 16'h0010, 32'h0, r, e, lat, w, wc, wa, ac);
    check_cnt++; if (e !== 1'b1 || r !== 32'h0) $display("FAIL f3_011: got err %b rdata %h want 1/0", e, r); else pass_cnt++;
    do_req(1'b1, F3_BU, 16'h0010, 32'h000000AA, r, e, lat, w, wc, wa, ac);
    check_cnt++; if (e !== 1'b1 || wc !== 0 || mem[16'h0010] !== 8'hEF) $display("FAIL store_bu: got err %b wen %0d mem %h want 1/0/ef", e, wc, mem[16'h0010]); else pass_cnt++;
    do_req(1'b0, F3_W, 16'hFFFC, 32'h0, r, e, lat, w, wc, wa, ac);
    check_cnt++; if (e !== 1'b0 || r !== 32'h0) $display("FAIL lw_top: got err %b rdata %h want 0/0", e, r); else pass_cnt++;
    do_req(1'b1, F3_H, 16'hFFFE, 32'h0000BEEF, r, e, lat, w, wc, wa, ac);
    check_cnt++; if (e !== 1'b0 || mem[16'hFFFF] !== 8'hBE || mem[16'hFFFE] !== 8'hEF || mem[0] !== 8'h00)
      $display("FAIL sh_top: got err %b mem %h%h next %h want 0 beef 00", e, mem[16'hFFFF], mem[16'hFFFE], mem[0]); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    int guard = 0;
    logic [31:0] r; logic e; int lat, wc, ac; logic [3:0] w; logic [15:0] wa;
    while (!bus.req_ready && guard < 20) begin @(posedge clk); #1; guard++; end
    bus.resp_ready = 1'b0;
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_funct3 = F3_W; bus.req_addr = 16'h0010;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    guard = 0;
    while (!bus.resp_valid && guard < 10) begin @(posedge clk); #1; guard++; end
    check_cnt++; if (bus.resp_valid !== 1'b1) $display("FAIL bp_resp_timeout: got %b want 1", bus.resp_valid); else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = F3_W;
      bus.req_addr = 16'h0010; bus.req_wdata = 32'h0;
      @(posedge clk); #1;
      check_cnt++; if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== 32'h123455EF)
        $display("FAIL bp_hold_%0d: got %b/%h want 1/123455ef", i, bus.resp_valid, bus.resp_rdata); else pass_cnt++;
      check_cnt++; if (bus.req_ready !== 1'b0 || sram_w_en !== 4'h0)
        $display("FAIL bp_ignore_%0d: got ready %b w_en %b want 0/0000", i, bus.req_ready, sram_w_en); else pass_cnt++;
    end
    bus.req_valid = 1'b0;
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    check_cnt++; if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1)
      $display("FAIL bp_release: got valid %b ready %b want 0/1", bus.resp_valid, bus.req_ready); else pass_cnt++;
    do_req(1'b0, F3_W, 16'h0010, 32'h0, r, e, lat, w, wc, wa, ac);
    check_cnt++; if (r !== 32'h123455EF) $display("FAIL bp_mem_intact: got %h want 123455ef", r); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] r1, r2; logic e; int lat, wc, ac1, ac2; logic [3:0] w; logic [15:0] wa;
    do_req(1'b0, F3_W, 16'h0010, 32'h0, r1, e, lat, w, wc, wa, ac1);
    do_req(1'b0, F3_HU, 16'h0012, 32'h0, r2, e, lat, w, wc, wa, ac2);
    check_cnt++; if (ac2 - ac1 !== 3) $display("FAIL b2b_interval: got %0d want 3", ac2 - ac1); else pass_cnt++;
    check_cnt++; if (r1 !== 32'h123455EF || r2 !== 32'h00001234)
      $display("FAIL b2b_data: got %h %h want 123455ef 00001234", r1, r2); else pass_cnt++;
  endtask

  task automatic test_reset_during_access();
    int guard = 0;
    logic [31:0] r; logic e; int lat, wc, ac; logic [3:0] w; logic [15:0] wa;
    do_req(1'b1, F3_W, 16'h0020, 32'h11223344, r, e, lat, w, wc, wa, ac);
    while (!bus.req_ready && guard < 20) begin @(posedge clk); #1; guard++; end
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = F3_W;
    bus.req_addr = 16'h0020; bus.req_wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    check_cnt++; if (sram_w_en !== 4'b1111) $display("FAIL rst_access_w_en: got %b want 1111", sram_w_en); else pass_cnt++;
    rst_n = 1'b0;
    #1;
    check_cnt++; if (sram_w_en !== 4'h0 || bus.resp_valid !== 1'b0 || dbg_state !== IDLE)
      $display("FAIL rst_access_clear: got w_en %b valid %b state %0d want 0000/0/0", sram_w_en, bus.resp_valid, dbg_state); else pass_cnt++;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_cnt++; if (bus.resp_valid !== 1'b0) $display("FAIL rst_no_resp: got %b want 0", bus.resp_valid); else pass_cnt++;
    do_req(1'b0, F3_W, 16'h0020, 32'h0, r, e, lat, w, wc, wa, ac);
    check_cnt++; if (r !== 32'h11223344) $display("FAIL rst_old_value: got %h want 11223344", r); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_extend();
    test_partial_store();
    test_errors();
    test_backpressure();
    test_back_to_back();
    test_reset_during_access();
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
